l3_shared_arbiter: RTL
======================

# l3_shared_arbiter

- Shared L3 port arbiter sitting directly below the per-core cache hierarchies.
- Accepts the L3 request bus from up to four cores and grants one request at a time, round-robin.
- Forwards the granted request to the single shared L3/backing-memory port and returns read data and a completion pulse to the requesting core only.
- Each core's L3 inputs (read data, valid, ready) connect to this block's per-core outputs.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores; fixed at 4 in this revision.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- core_addr  in  NUM_CORES*ADDR_W  per-core address; core i at bits [i*8+:8].
- core_read_enable  in  NUM_CORES  per-core read request, level, held until completion.
- core_write_enable  in  NUM_CORES  per-core write request, level, held until completion.
- core_write_data  in  NUM_CORES*DATA_W  per-core write data.
- core_read_data  out  NUM_CORES*DATA_W  per-core read data; valid only with core_valid[i].
- core_valid  out  NUM_CORES  one-cycle completion pulse per core (reads and writes).
- core_ready  out  NUM_CORES  arbiter idle and able to sample a request this cycle.
- mem_addr  out  ADDR_W  shared L3 address.
- mem_read_enable  out  1  shared read strobe, held until mem_ack.
- mem_write_enable  out  1  shared write strobe, held until mem_ack.
- mem_write_data  out  DATA_W  shared write data.
- mem_read_data  in  DATA_W  L3 read data, valid with mem_ack.
- mem_ack  in  1  L3 completion for current access; may be high in the first enable cycle.

## Operation
- FSM states: IDLE, MEM, RESP.
- **IDLE**
  - Eligible[i] = (core_read_enable[i] | core_write_enable[i]) & !served[i].
  - If any core is eligible, pick the first eligible index after last_grant (wrap 3→0).
  - Latch grant index, addr, write data and op; go to MEM.
  - Write wins if a core asserts both read and write enables.
- **MEM**
  - Drive mem_* from the latched registers; hold the enables until mem_ack.
  - On mem_ack: capture mem_read_data (reads) and go to RESP.
- **RESP**
  - Pulse core_valid[grant] for one cycle.
  - Drive core_read_data[grant] (reads; writes return 0).
  - Set served[grant]; last_grant ← grant; go to IDLE.
- **served[i]**: cleared in any cycle where core i has both enables low. A core holding its request past completion is therefore never served twice.
- Non-granted core_read_data lanes hold their last value; core_valid stays 0.
- Request inputs are sampled only in IDLE; changes in MEM/RESP are ignored until the next arbitration.

## Timing
- **Reset values:** state=IDLE, last_grant=3 (core 0 has first priority), served=0, core_valid=0, core_read_data=0, mem enables=0, mem_addr=0, mem_write_data=0, core_ready=all 1s.
- **core_ready:** all bits 1 exactly when state==IDLE, decoded from the state register.
- **Latency:**
  - Request visible in IDLE at cycle 0 → mem enable asserted in cycle 1.
  - Zero-wait mem_ack in cycle 1 → core_valid in cycle 2.
  - Each extra ack wait cycle adds 1.
- **Throughput:** one access per 3 cycles minimum (IDLE–MEM–RESP).
- **Simultaneous requests:** strict rotation. With all four requesting continuously, grants follow 0,1,2,3,0…
- **Reset mid-operation:** the FSM returns to IDLE at the reset edge; mem enables drop; the in-flight access is abandoned with no core_valid.
- No timeout: MEM waits indefinitely for mem_ack.

## Configuration
- Macro: L3_ARB_STATS_EN.
- **Defined:**
  - Adds output grant_count, NUM_CORES*8 bits.
  - Per-core 8-bit grant counter incremented in RESP, saturating at 255, reset to 0.
  - Adds output contention_count, 8 bits, saturating; increments on each IDLE arbitration with ≥2 eligible cores.
- **Undefined:** neither port nor its counters exist; all other behaviour is identical.

## Structure
- Package l3_arb_pkg holds:
  - NUM_CORES, ADDR_W, DATA_W;
  - the state enum (IDLE, MEM, RESP);
  - the 2-bit core index typedef.
- Sub-module rr_arbiter_4: combinational round-robin pick.
  - Inputs: 4-bit eligible vector and last_grant.
  - Outputs: grant index and any_valid.
  - Instantiated once.

## Test plan
- Core 2 reads addr 0x40; mem_ack same cycle as enable, mem_read_data=0xA5 → core_valid[2] at cycle 2, core_read_data lane 2 = 0xA5, other valids 0.
- All four cores write distinct data after reset → mem writes issue in order 0,1,2,3 with matching addr/data; each core_valid pulses once.
- Core 1 holds its read enable 10 cycles after completion → exactly one grant; after the enable drops and rises again, a second grant occurs.
- mem_ack delayed 5 cycles → mem enables stay high throughout; core_valid arrives 5 cycles later than zero-wait.
- Reset asserted during MEM → next cycle all mem enables 0, no core_valid, core_ready=1111, and the next grant goes to core 0.
- With L3_ARB_STATS_EN: core 3 granted 300 times → grant_count lane 3 = 255.

Source files
------------

// File: rtl/l3_arb_pkg.sv
// Shared definitions for the L3 port arbiter: sizes, FSM state encoding and core index type.
// Optional statistics are enabled with the L3_ARB_STATS_EN macro in l3_shared_arbiter.
package l3_arb_pkg;

   localparam int NUM_CORES = 4;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef logic [1:0] core_idx_t;

   // True when at least two bits are set (clearing the lowest set bit leaves something).
   function automatic logic multi_hot(input logic [NUM_CORES-1:0] v);
      return |(v & (v - NUM_CORES'(1)));
   endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational round-robin pick over four requesters: the first eligible index
// strictly after last_grant, wrapping 3 -> 0 (last_grant itself is checked last).
module rr_arbiter_4
   import l3_arb_pkg::*;
(
   input  logic [3:0] eligible,
   input  core_idx_t  last_grant,
   output core_idx_t  grant,
   output logic       any_valid
);

   core_idx_t idx;

   always_comb begin
      grant     = last_grant;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant + core_idx_t'(k);
         if (!any_valid && eligible[idx]) begin
            grant     = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l3_shared_arbiter.sv
// Round-robin arbiter multiplexing four cores' L3 requests onto one shared memory port.
// Define L3_ARB_STATS_EN to add per-core grant counters and a contention counter.
module l3_shared_arbiter
   import l3_arb_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES-1:0]        core_read_enable,
   input  logic [NUM_CORES-1:0]        core_write_enable,
   input  logic [NUM_CORES*DATA_W-1:0] core_write_data,
   output logic [NUM_CORES*DATA_W-1:0] core_read_data,
   output logic [NUM_CORES-1:0]        core_valid,
   output logic [NUM_CORES-1:0]        core_ready,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_read_enable,
   output logic                        mem_write_enable,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data,
   input  logic                        mem_ack,
`ifdef L3_ARB_STATS_EN
   output logic [NUM_CORES*8-1:0]      grant_count,
   output logic [7:0]                  contention_count,
`endif
   output logic [1:0]                  state_dbg
);

   // Handshake: a core holds its read/write enable as a level until its one-cycle
   // core_valid; core_ready=1 means the request is sampled this cycle. Toward memory,
   // the enable is held until mem_ack, which may already be high in the first cycle.

   arb_state_e                  state_q, state_d;
   core_idx_t                   grant_q, last_grant_q, pick;
   logic                        any_eligible;
   logic [NUM_CORES-1:0]        served_q, active, eligible, resp_onehot;
   logic [ADDR_W-1:0]           addr_q;
   logic [DATA_W-1:0]           wdata_q;
   logic                        write_q;
   logic [NUM_CORES*DATA_W-1:0] rdata_q;

   assign active      = core_read_enable | core_write_enable;
   assign eligible    = active & ~served_q;
   assign resp_onehot = (state_q == RESP) ? (NUM_CORES'(1) << grant_q) : '0;

   rr_arbiter_4 u_rr (
      .eligible   (eligible),
      .last_grant (last_grant_q),
      .grant      (pick),
      .any_valid  (any_eligible)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_eligible) state_d = MEM;
         MEM:     if (mem_ack) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_q      <= '0;
         last_grant_q <= core_idx_t'(NUM_CORES - 1);
         served_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
      end else begin
         // A held request stays marked served until the core drops both enables.
         served_q <= (served_q | resp_onehot) & active;
         if (state_q == IDLE && any_eligible) begin
            grant_q <= pick;
            addr_q  <= core_addr[pick*ADDR_W +: ADDR_W];
            wdata_q <= core_write_data[pick*DATA_W +: DATA_W];
            write_q <= core_write_enable[pick];
         end
         if (state_q == MEM && mem_ack)
            rdata_q[grant_q*DATA_W +: DATA_W] <= write_q ? '0 : mem_read_data;
         if (state_q == RESP)
            last_grant_q <= grant_q;
      end
   end

   assign core_ready       = {NUM_CORES{state_q == IDLE}};
   assign core_valid       = resp_onehot;
   assign core_read_data   = rdata_q;
   assign mem_addr         = addr_q;
   assign mem_write_data   = wdata_q;
   assign mem_read_enable  = (state_q == MEM) && !write_q;
   assign mem_write_enable = (state_q == MEM) && write_q;
   assign state_dbg        = state_q;

`ifdef L3_ARB_STATS_EN
   logic [NUM_CORES*8-1:0] grant_cnt_q;
   logic [7:0]             contention_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_cnt_q  <= '0;
         contention_q <= '0;
      end else begin
         if (state_q == RESP && grant_cnt_q[grant_q*8 +: 8] != 8'hFF)
            grant_cnt_q[grant_q*8 +: 8] <= grant_cnt_q[grant_q*8 +: 8] + 8'd1;
         if (state_q == IDLE && multi_hot(eligible) && contention_q != 8'hFF)
            contention_q <= contention_q + 8'd1;
      end
   end

   assign grant_count      = grant_cnt_q;
   assign contention_count = contention_q;
`endif

endmodule
